// File: rtl/sync_fifo_sram_param_pkg.sv
// rtl/sync_fifo_sram_param_pkg.sv - shared sizing helpers for the SRAM-backed FIFO
package sync_fifo_sram_param_pkg;

  // Number of words addressed by an SRAM with the given address width
  function automatic int sfs_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // Occupancy at which almost_full asserts
  function automatic int sfs_af_threshold(input int depth, input int margin);
    return depth - margin;
  endfunction

endpackage

// File: rtl/sync_fifo_sram_param_sram.sv
// rtl/sync_fifo_sram_param_sram.sv - dual-port SRAM, sync write, registered read with hold
module dual_port_sync_sram_param
  import sync_fifo_sram_param_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_write_enable,
  input  logic [ADDR_BITS-1:0] i_write_addr,
  input  logic [WIDTH-1:0]     i_write_data,
  input  logic                 i_read_enable,
  input  logic [ADDR_BITS-1:0] i_read_addr,
  output logic [WIDTH-1:0]     o_read_data
);

  localparam int DEPTH = sfs_depth(ADDR_BITS);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_read_data;

  // Array and read register carry no reset; the read register holds while read_enable is low
  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      r_mem[i_write_addr] <= i_write_data;
    end
    if (i_read_enable) begin
      r_read_data <= r_mem[i_read_addr];
    end
  end

  assign o_read_data = r_read_data;

endmodule

// File: rtl/sync_fifo_sram_param.sv
// rtl/sync_fifo_sram_param.sv - FWFT FIFO on a sync-read SRAM with flags, count and sticky errors
module sync_fifo_sram_param
  import sync_fifo_sram_param_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 flush,
  input  logic                 write_enable,
  input  logic [WIDTH-1:0]     write_data,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 read_take,
  output logic [WIDTH-1:0]     read_data,
  output logic                 read_data_valid,
  output logic [ADDR_BITS:0]   word_count,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int            DEPTH   = sfs_depth(ADDR_BITS);
  localparam int            CW      = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(sfs_af_threshold(DEPTH, AF_MARGIN));
  localparam logic          AF_RST  = (AF_MARGIN == DEPTH);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_almost_full;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic                 r_inflight;
  logic                 r_overflow;
  logic                 r_underflow;

  logic                 w_wr_acc;
  logic                 w_take_acc;
  logic                 w_move;
  logic                 w_issue;
  logic [CW-1:0]        w_sram_cnt;
  logic [CW-1:0]        w_count_nxt;
  logic [WIDTH-1:0]     w_sram_rdata;

  // Accepted operations; full blocks writes even when a take frees a slot this cycle
  assign w_wr_acc   = write_enable & ~r_full;
  assign w_take_acc = read_take & r_out_valid;

  // r_inflight means the SRAM read register holds a word not yet moved to the output register
  assign w_move     = r_inflight & (~r_out_valid | w_take_acc);

  // Words still sitting in the SRAM that have not had a read issued
  assign w_sram_cnt = r_count - CW'(r_out_valid) - CW'(r_inflight);

  // Issue a read only when the SRAM read register will be free at this edge
  assign w_issue    = ~flush & (w_sram_cnt != '0) & (~r_inflight | w_move);

  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_take_acc);

  dual_port_sync_sram_param #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_sram (
    .i_clk          (clk),
    .i_write_enable (w_wr_acc & ~flush),
    .i_write_addr   (r_wr_ptr),
    .i_write_data   (write_data),
    .i_read_enable  (w_issue),
    .i_read_addr    (r_rd_ptr),
    .o_read_data    (w_sram_rdata)
  );

  // Write and read pointers; both wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      end
    end
  end

  // Occupancy and the flags derived from the post-edge count
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= AF_RST;
    end else if (flush) begin
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= AF_RST;
    end else begin
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == DEPTH_C);
      r_almost_full <= (w_count_nxt >= AF_TH);
    end
  end

  // Output register fed from the SRAM read register; data holds when nothing loads
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_inflight  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sram_rdata;
      end else if (w_take_acc) begin
        r_out_valid <= 1'b0;
      end
      r_inflight <= w_issue | (r_inflight & ~w_move);
    end
  end

  // Sticky error flags, cleared only by flush or reset
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable & r_full) begin
        r_overflow <= 1'b1;
      end
      if (read_take & ~r_out_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign full            = r_full;
  assign almost_full     = r_almost_full;
  assign read_data       = r_out_data;
  assign read_data_valid = r_out_valid;
  assign word_count      = r_count;
  assign overflow_err    = r_overflow;
  assign underflow_err   = r_underflow;

endmodule
